imm_gen_stage: RTL

//  Registered RISC-V immediate generator for the decode stage. Successor to the combinational extender.

---
 rtl/imm_gen_pkg.sv | 37 +++
 rtl/imm_decode.sv | 52 +++++
 rtl/imm_gen_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared constants and helpers for the RISC-V immediate generator.
// The decode-stage wrapper and the combinational decoder both import this package.
package imm_gen_pkg;

    localparam logic [2:0] EXT_NONE   = 3'b000;
    localparam logic [2:0] EXT_S      = 3'b001;
    localparam logic [2:0] EXT_I      = 3'b010;
    localparam logic [2:0] EXT_ISHAMT = 3'b011;
    localparam logic [2:0] EXT_B      = 3'b100;
    localparam logic [2:0] EXT_U      = 3'b101;
    localparam logic [2:0] EXT_J      = 3'b110;
    localparam logic [2:0] EXT_AUTO   = 3'b111;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int unsigned MAX_XLEN = 64;

    // Sign-extend the low 'width' bits of val (upper bits of val must be zero) to 64 bits.
    function automatic logic [MAX_XLEN-1:0] sext(input logic [31:0] val, input int unsigned width);
        logic [MAX_XLEN-1:0] r;
        logic                s;
        s = val[5'(width - 1)];
        r = {32'b0, val};
        for (int unsigned i = 0; i < MAX_XLEN; i++) begin
            if (i >= width) r[i] = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction + extop to immediate decoder, no state.
// Shared between the registered decode stage and the single-cycle core.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      extop,
    output logic [XLEN-1:0] imm_c,
    output logic            illegal_c
);

    logic [2:0]          fmt;
    logic [MAX_XLEN-1:0] wide;

    // Resolve AUTO to a concrete format, then build the 64-bit form and trim to XLEN.
    always_comb begin
        fmt       = extop;
        illegal_c = 1'b0;
        wide      = '0;

        if (extop == EXT_AUTO) begin
            case (instr[6:0])
                OP_IMM:            fmt = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                                         ? EXT_ISHAMT : EXT_I;
                OP_LOAD, OP_JALR:  fmt = EXT_I;
                OP_STORE:          fmt = EXT_S;
                OP_BRANCH:         fmt = EXT_B;
                OP_LUI, OP_AUIPC:  fmt = EXT_U;
                OP_JAL:            fmt = EXT_J;
                default: begin
                    fmt       = EXT_NONE;
                    illegal_c = 1'b1;
                end
            endcase
        end

        case (fmt)
            EXT_I:      wide = sext({20'b0, instr[31:20]}, 12);
            EXT_S:      wide = sext({20'b0, instr[31:25], instr[11:7]}, 12);
            EXT_B:      wide = sext({19'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
            EXT_U:      wide = sext({instr[31:12], 12'b0}, 32);
            EXT_J:      wide = sext({11'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
            EXT_ISHAMT: wide = (XLEN == 64) ? 64'(instr[25:20]) : 64'(instr[24:20]);
            default:    wide = '0;
        endcase

        imm_c = wide[XLEN-1:0];
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decode ahead of a 2-entry valid/ready skid buffer
// carrying immediate, illegal flag and a passthrough tag, with flush and stall.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_extop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int unsigned DEPTH = 2;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic [XLEN-1:0]  ent_imm [DEPTH];
    logic [TAG_W-1:0] ent_tag [DEPTH];
    logic [DEPTH-1:0] ent_ill;
    logic             head, head_nxt;
    logic             tail, tail_nxt;
    logic [1:0]       count, count_nxt;
    logic             wr_en;
    logic             push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr     (in_instr),
        .extop     (in_extop),
        .imm_c     (dec_imm),
        .illegal_c (dec_ill)
    );

    assign in_ready  = rstn && (count != 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer/occupancy update; flush wins over any concurrent push or pop.
    always_comb begin
        count_nxt = count;
        head_nxt  = head;
        tail_nxt  = tail;
        wr_en     = 1'b0;
        if (flush) begin
            count_nxt = 2'd0;
            head_nxt  = 1'b0;
            tail_nxt  = 1'b0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                tail_nxt = ~tail;
            end
            if (pop) head_nxt = ~head;
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_imm[i] <= '0;
                ent_tag[i] <= '0;
            end
            ent_ill <= '0;
        end else begin
            count <= count_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
            if (wr_en) begin
                ent_imm[tail] <= dec_imm;
                ent_tag[tail] <= in_tag;
                ent_ill[tail] <= dec_ill;
            end
        end
    end

    // Outputs are the head-entry registers, so they cannot move while the head is held.
    assign out_imm     = ent_imm[head];
    assign out_tag     = ent_tag[head];
    assign out_illegal = ent_ill[head];

endmodule
